// File: rtl/seg7_pkg.sv
// Shared types and segment constants for the multiplexed seven-segment driver.
// Segment bit order is a..g on bits 0..6, active-low.
package seg7_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_e;

  localparam int unsigned SEG_W  = 7;
  localparam int unsigned NIB_W  = 4;

  localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

  localparam logic [SEG_W-1:0] SEG_0 = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8 = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9 = 7'h10;
  localparam logic [SEG_W-1:0] SEG_A = 7'h08;
  localparam logic [SEG_W-1:0] SEG_B = 7'h03;
  localparam logic [SEG_W-1:0] SEG_C = 7'h46;
  localparam logic [SEG_W-1:0] SEG_D = 7'h21;
  localparam logic [SEG_W-1:0] SEG_E = 7'h06;
  localparam logic [SEG_W-1:0] SEG_F = 7'h0E;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Request/display bundle between the display client (master) and the scan driver (slave).
interface seg7_scan_driver_if
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8
) ();

  logic                      scan_tick;
  logic                      load;
  logic [NIB_W*NUM_DIGITS-1:0] data_in;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic [NUM_DIGITS-1:0]     an_n;
  logic [SEG_W-1:0]          seg_n;
  logic                      dp_n;
  logic                      frame_done;
  logic                      pending;

  modport master (
    output scan_tick, load, data_in, dp_in,
    input  an_n, seg_n, dp_n, frame_done, pending
  );

  modport slave (
    input  scan_tick, load, data_in, dp_in,
    output an_n, seg_n, dp_n, frame_done, pending
  );

endinterface

// File: rtl/hex7seg_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex7seg_decode
  import seg7_pkg::*;
(
  input  logic [NIB_W-1:0] nibble,
  output logic [SEG_W-1:0] seg_n_c
);

  always_comb begin
    seg_n_c = SEG_OFF;
    case (nibble)
      4'h0: seg_n_c = SEG_0;
      4'h1: seg_n_c = SEG_1;
      4'h2: seg_n_c = SEG_2;
      4'h3: seg_n_c = SEG_3;
      4'h4: seg_n_c = SEG_4;
      4'h5: seg_n_c = SEG_5;
      4'h6: seg_n_c = SEG_6;
      4'h7: seg_n_c = SEG_7;
      4'h8: seg_n_c = SEG_8;
      4'h9: seg_n_c = SEG_9;
      4'hA: seg_n_c = SEG_A;
      4'hB: seg_n_c = SEG_B;
      4'hC: seg_n_c = SEG_C;
      4'hD: seg_n_c = SEG_D;
      4'hE: seg_n_c = SEG_E;
      4'hF: seg_n_c = SEG_F;
      default: seg_n_c = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver with frame-aligned shadow commit and dead-time blanking.
// Optional leading-zero suppression: define SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned DEAD_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  seg7_scan_driver_if.slave   bus
);

  localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
  localparam int unsigned DEAD_W = $clog2(DEAD_CYCLES + 1);
  localparam int unsigned DATA_W = NIB_W * NUM_DIGITS;

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DEAD_W-1:0] DEAD_INIT = DEAD_W'(DEAD_CYCLES);

  state_e                 state_q, state_d;
  logic [DEAD_W-1:0]      dead_q, dead_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DATA_W-1:0]      shadow_data_q, shadow_data_d;
  logic [NUM_DIGITS-1:0]  shadow_dp_q, shadow_dp_d;
  logic [DATA_W-1:0]      pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0]  pend_dp_q, pend_dp_d;
  logic                   pending_q, pending_d;
  logic                   frame_done_q, frame_done_d;
  logic [NUM_DIGITS-1:0]  an_n_q, an_n_d;
  logic [SEG_W-1:0]       seg_n_q, seg_n_d;
  logic                   dp_n_q, dp_n_d;

  logic                   wrap_c;
  logic [NIB_W-1:0]       nibble_sel_c;
  logic                   dp_sel_c;
  logic                   suppress_c;
  logic [SEG_W-1:0]       seg_dec_c;

  // Scan FSM plus pending/shadow bookkeeping; the shadow only changes on the wrap tick.
  always_comb begin
    state_d       = state_q;
    dead_d        = dead_q;
    idx_d         = idx_q;
    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;
    pend_data_d   = pend_data_q;
    pend_dp_d     = pend_dp_q;
    pending_d     = pending_q;
    frame_done_d  = 1'b0;
    wrap_c        = 1'b0;

    unique case (state_q)
      BLANK: begin
        if (dead_q <= DEAD_W'(1)) begin
          state_d = SHOW;
          dead_d  = '0;
        end else begin
          dead_d  = dead_q - DEAD_W'(1);
        end
      end
      SHOW: begin
        if (bus.scan_tick) begin
          state_d = BLANK;
          dead_d  = DEAD_INIT;
          if (idx_q == IDX_LAST) begin
            idx_d  = '0;
            wrap_c = 1'b1;
          end else begin
            idx_d  = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = BLANK;
    endcase

    if (bus.load) begin
      pend_data_d = bus.data_in;
      pend_dp_d   = bus.dp_in;
      pending_d   = 1'b1;
    end

    // A load coinciding with the commit bypasses the pending registers.
    if (wrap_c) begin
      frame_done_d = 1'b1;
      pending_d    = 1'b0;
      if (bus.load) begin
        shadow_data_d = bus.data_in;
        shadow_dp_d   = bus.dp_in;
      end else if (pending_q) begin
        shadow_data_d = pend_data_q;
        shadow_dp_d   = pend_dp_q;
      end
    end
  end

  // Select the upcoming digit's nibble and dp from next-state values so outputs track the FSM edge.
  always_comb begin
    nibble_sel_c = '0;
    dp_sel_c     = 1'b0;
    suppress_c   = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_d == IDX_W'(k)) begin
        nibble_sel_c = shadow_data_d[NIB_W*k +: NIB_W];
        dp_sel_c     = shadow_dp_d[k];
      end
    end
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    begin : lzb
      logic zero_above;
      zero_above = 1'b1;
      for (int k = NUM_DIGITS - 1; k > 0; k--) begin
        zero_above = zero_above & (shadow_data_d[NIB_W*k +: NIB_W] == '0);
        if ((idx_d == IDX_W'(k)) && zero_above && !shadow_dp_d[k]) begin
          suppress_c = 1'b1;
        end
      end
    end
`endif
  end

  hex7seg_decode u_decode (
    .nibble  (nibble_sel_c),
    .seg_n_c (seg_dec_c)
  );

  always_comb begin
    an_n_d  = '1;
    seg_n_d = SEG_OFF;
    dp_n_d  = 1'b1;
    if ((state_d == SHOW) && !suppress_c) begin
      an_n_d  = ~(NUM_DIGITS'(1) << idx_d);
      seg_n_d = seg_dec_c;
      dp_n_d  = ~dp_sel_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BLANK;
      dead_q        <= DEAD_INIT;
      idx_q         <= '0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      pend_data_q   <= '0;
      pend_dp_q     <= '0;
      pending_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      an_n_q        <= '1;
      seg_n_q       <= SEG_OFF;
      dp_n_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      dead_q        <= dead_d;
      idx_q         <= idx_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      pend_data_q   <= pend_data_d;
      pend_dp_q     <= pend_dp_d;
      pending_q     <= pending_d;
      frame_done_q  <= frame_done_d;
      an_n_q        <= an_n_d;
      seg_n_q       <= seg_n_d;
      dp_n_q        <= dp_n_d;
    end
  end

  assign bus.an_n       = an_n_q;
  assign bus.seg_n      = seg_n_q;
  assign bus.dp_n       = dp_n_q;
  assign bus.frame_done = frame_done_q;
  assign bus.pending    = pending_q;

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Multiplexed seven-segment display driver that sits directly downstream of the free-running refresh prescaler. Each one-cycle `scan_tick` from the prescaler advances it to the next digit. It holds a tear-free shadow copy of the displayed hex value and inserts an all-off dead time between digits to prevent ghosting. It drives the board's common-anode digit enables and the segment lines, all active-low.

## Interface
- `NUM_DIGITS`, 8: number of digits scanned; range 2..8.
- `DEAD_CYCLES`, 4: clocks of all-off blanking after each digit change; must be ≥1.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `scan_tick`  in  1  one-cycle pulse from the refresh prescaler; advances the scan.
- `load`  in  1  one-cycle request to display a new value.
- `data_in`  in  4*NUM_DIGITS  hex nibbles; nibble k is shown on digit k (digit 0 rightmost).
- `dp_in`  in  NUM_DIGITS  decimal-point enables, captured together with `data_in`.
- `an_n`  out  NUM_DIGITS  digit enables, active-low, one-hot-low or all-high.
- `seg_n`  out  7  segments a..g on bits 0..6, active-low.
- `dp_n`  out  1  decimal point, active-low.
- `frame_done`  out  1  one-cycle pulse when a new frame begins (commit point).
- `pending`  out  1  high while a loaded value awaits commit.

## Operation
- FSM has two states, BLANK and SHOW.
  - BLANK: `an_n`, `seg_n` and `dp_n` are all ones. A dead counter counts down from DEAD_CYCLES. When it reaches 0, the FSM goes to SHOW.
  - SHOW: `an_n[idx]`=0 and all other anode bits are 1. `seg_n` is the decode of shadow nibble `idx`. `dp_n` = ~shadow_dp[idx].
  - On `scan_tick` in SHOW: `idx` advances, the dead counter reloads with DEAD_CYCLES, and the FSM goes to BLANK.
  - `scan_tick` while in BLANK is ignored; the scan does not advance or queue.
- `idx` wraps from NUM_DIGITS-1 to 0. On that wrap transition:
  - If `pending`=1, the pending registers are copied to the shadow and `pending` clears.
  - `frame_done` pulses on the same edge, whether or not a commit occurred.
- `load`=1 copies `data_in`/`dp_in` into the pending registers and sets `pending`.
  - A later load before commit overwrites the earlier one; only the last value is shown.
- `load` on the same cycle as a wrap commit: the commit uses the current `data_in`/`dp_in` (bypass), and `pending` ends at 0.
- Digit contents change only at the frame boundary, never mid-frame.
- Reset values:
  - State BLANK, dead counter = DEAD_CYCLES, `idx`=0.
  - Shadow and pending registers all 0; `pending`=0.
  - `an_n` all ones, `seg_n` 7'h7F, `dp_n`=1, `frame_done`=0.
- Reset asserted mid-frame or mid-dead-time: all of the above apply on the next edge. Any pending value is lost.

## Timing
- All outputs are registered and change on the same edge as the FSM transition that causes them.
- After reset deasserts, the first SHOW of digit 0 begins DEAD_CYCLES clocks later.
- `scan_tick` at edge N in SHOW: `an_n` is all ones from edge N+1. The next digit is lit from edge N+1+DEAD_CYCLES.
- `load` at edge N: `pending`=1 from N+1. Commit and `frame_done` happen on the next wrap tick.
- Upstream requirement: `scan_tick` period must exceed DEAD_CYCLES+1 clocks. Faster ticks are dropped by design.

## Configuration
- `SEG7_LEADING_ZERO_BLANK_EN` defined: leading-zero suppression is active.
  - A digit k > 0 is suppressed when shadow nibble k and every higher nibble are 0 and its dp bit is 0.
  - A suppressed digit keeps its time slot, but `an_n` stays all ones during its SHOW period.
  - Digit 0 is never suppressed.
- `SEG7_LEADING_ZERO_BLANK_EN` undefined: every digit is lit during its slot, including leading zeros.

## Structure
- Shared package `seg7_pkg`:
  - FSM state enum (BLANK, SHOW).
  - Active-low segment constants for 0–F.
  - Constant SEG_OFF = 7'h7F.
- Sub-module `hex7seg_decode`: purely combinational, 4-bit nibble to 7-bit active-low `seg_n`. Instantiated once and fed by the shadow-nibble mux.

## Test plan
- Reset check: rst=1 for 3 clocks, release. Then `an_n`=8'hFF and `seg_n`=7'h7F for exactly 4 clocks, after which `an_n`=8'hFE.
- Load 32'h0000_1234 with `dp_in`=8'h04, then tick through one frame. Expect `pending`=1 until the wrap, `frame_done` pulse, and in the next frame:
  - digit 0 `seg_n`=7'h19 (4);
  - digit 2 `seg_n`=7'h24 (2) with `dp_n`=0.
- Two loads mid-frame (32'h11111111 then 32'h22222222): only 2 is displayed after the commit; 1 never appears on any digit.
- Load pulsed on the same cycle as the digit-7 tick: the new value is live on digit 0 of the immediately following frame, and `pending`=0.
- `scan_tick` pulsed 2 clocks after a previous tick (inside BLANK): ignored, and `idx` advances only once.
- With `SEG7_LEADING_ZERO_BLANK_EN`, load 32'h0000_0050: digits 7..2 keep `an_n`=8'hFF during their slots, and digits 1 and 0 light showing 5 and 0.
